// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the program-memory bootloader.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CSUM
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  // Bit period for the default 27 MHz / 115200 baud build.
  localparam int CLKS_PER_BIT = 27000000 / 115200;

  function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/prog_mem_loader_if.sv
// CPU fetch port plus bootloader serial line and status flags.
interface prog_mem_loader_if;
  logic        uart_rx;
  logic [10:0] adr;
  logic [15:0] dout;
  logic        cpu_reset;
  logic        loading;
  logic        load_err;

  modport master (output uart_rx, adr, input dout, cpu_reset, loading, load_err);
  modport slave  (input uart_rx, adr, output dout, cpu_reset, loading, load_err);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle valid/ferr strobes.
module uart_rx_byte
  import prog_loader_pkg::*;
#(
  parameter int CPB = CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr
);

  localparam int CNT_W = $clog2(CPB + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CPB / 2 - 1);

  rx_state_t        state_reg, state_next;
  logic [2:0]       sync_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2:0]       bit_reg;
  logic [7:0]       shift_reg;
  logic             rx_s, fall, tick;

  // sync_reg[2] is the previous synchronized sample, used for edge detection.
  assign rx_s    = sync_reg[1];
  assign fall    = sync_reg[2] & ~sync_reg[1];
  assign rx_data = shift_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_reg  <= 3'b111;
      state_reg <= RX_IDLE;
    end else begin
      sync_reg  <= {sync_reg[1:0], rx};
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_reg == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_comb begin
    tick     = 1'b0;
    rx_valid = 1'b0;
    rx_ferr  = 1'b0;
    case (state_reg)
      RX_START:         tick = (cnt_reg == HALF);
      RX_DATA, RX_STOP: tick = (cnt_reg == FULL);
      default:          tick = 1'b0;
    endcase
    rx_valid = (state_reg == RX_STOP) && tick && rx_s;
    rx_ferr  = (state_reg == RX_STOP) && tick && !rx_s;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_reg   <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      cnt_reg <= (state_reg == RX_IDLE || tick) ? '0 : cnt_reg + CNT_W'(1);
      if (state_reg == RX_IDLE) begin
        bit_reg <= '0;
      end else if (state_reg == RX_DATA && tick) begin
        shift_reg <= {rx_s, shift_reg[7:1]};
        bit_reg   <= bit_reg + 3'd1;
      end
    end
  end

endmodule

// File: rtl/prog_mem_loader.sv
// Instruction memory with zero-latency fetch and a UART frame bootloader
// that holds the CPU in reset until a checksummed image has been written.
module prog_mem_loader
  import prog_loader_pkg::*;
#(
  parameter int    CLK_HZ    = 27000000,
  parameter int    BAUD      = 115200,
  parameter int    DEPTH_W   = 8,
  parameter string INIT_FILE = "",
  parameter bit    AUTO_RUN  = 1'b1,
  parameter int    TIMEOUT   = 2700000
) (
  input logic              clk,
  input logic              reset,
  prog_mem_loader_if.slave bus
);

  localparam int DEPTH = 2 ** DEPTH_W;
  localparam int CNT_W = DEPTH_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 2);

  logic [15:0] mem [DEPTH];

  logic        rx_valid, rx_ferr;
  logic [7:0]  rx_data;
  load_state_t state_reg, state_next;
  logic [15:0] len_reg, len_now;
  logic [7:0]  hi_reg, csum_reg;
  logic [CNT_W-1:0] word_reg;
  logic [TMR_W-1:0] timer_reg;
  logic        load_err_reg, cpu_reset_reg;
  logic        len_bad, last_word, timeout, mid_abort, step;
  logic        start, abort, done, mem_we, csum_add;
  logic        adr_hi_unused;

  // Fetch address wraps: bits above DEPTH_W are don't-care.
  assign bus.dout      = mem[bus.adr[DEPTH_W-1:0]];
  assign adr_hi_unused = ^bus.adr[10:DEPTH_W];
  assign bus.loading   = (state_reg != IDLE);
  assign bus.load_err  = load_err_reg;
  assign bus.cpu_reset = cpu_reset_reg;

  uart_rx_byte #(.CPB(calc_clks_per_bit(CLK_HZ, BAUD))) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (bus.uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ferr  (rx_ferr)
  );

  assign len_now   = {len_reg[15:8], rx_data};
  assign len_bad   = (len_now == 16'd0) || ({1'b0, len_now} > 17'(DEPTH));
  assign last_word = (16'(word_reg) + 16'd1) == len_reg;
  assign timeout   = timer_reg >= TMR_W'(TIMEOUT);

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (state_reg != IDLE && (rx_ferr || timeout)) begin
      state_next = IDLE;
    end else if (rx_valid) begin
      case (state_reg)
        IDLE:    if (rx_data == SYNC_BYTE) state_next = LEN_HI;
        LEN_HI:  state_next = LEN_LO;
        LEN_LO:  state_next = len_bad ? IDLE : DATA_HI;
        DATA_HI: state_next = DATA_LO;
        DATA_LO: state_next = last_word ? CSUM : DATA_HI;
        CSUM:    state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    mid_abort = (state_reg != IDLE) && (rx_ferr || timeout);
    step      = rx_valid && !mid_abort;
    start     = (state_reg == IDLE) && rx_valid && (rx_data == SYNC_BYTE);
    done      = step && (state_reg == CSUM) && (rx_data == csum_reg);
    abort     = mid_abort || (step && (((state_reg == LEN_LO) && len_bad) ||
                                       ((state_reg == CSUM) && (rx_data != csum_reg))));
    mem_we    = step && (state_reg == DATA_LO);
    csum_add  = step && (state_reg inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      len_reg       <= '0;
      hi_reg        <= '0;
      csum_reg      <= '0;
      word_reg      <= '0;
      timer_reg     <= '0;
      load_err_reg  <= 1'b0;
      cpu_reset_reg <= AUTO_RUN;
    end else begin
      if (start)         csum_reg <= '0;
      else if (csum_add) csum_reg <= csum_reg + rx_data;
      if (step && state_reg == LEN_HI)  len_reg[15:8] <= rx_data;
      if (step && state_reg == LEN_LO)  len_reg <= len_now;
      if (step && state_reg == DATA_HI) hi_reg <= rx_data;
      if (start)       word_reg <= '0;
      else if (mem_we) word_reg <= word_reg + CNT_W'(1);
      // Inter-byte timer only runs inside a frame and restarts on every byte.
      if (state_reg == IDLE || rx_valid) timer_reg <= '0;
      else if (!timeout)                 timer_reg <= timer_reg + TMR_W'(1);
      if (start)      load_err_reg <= 1'b0;
      else if (abort) load_err_reg <= 1'b1;
      if (start)     cpu_reset_reg <= 1'b0;
      else if (done) cpu_reset_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_we) mem[word_reg[DEPTH_W-1:0]] <= {hi_reg, rx_data};
  end

endmodule

// File: tb/tb_prog_mem_loader.sv
// Frame-level bench for prog_mem_loader: table of frames, random frames, and
// hand-built timeout / framing-error / mid-frame reset sequences.
module tb_prog_mem_loader;

  localparam int CLK_HZ  = 460800;
  localparam int BAUD    = 115200;
  localparam int CPB     = CLK_HZ / BAUD;
  localparam int TIMEOUT = 200;
  localparam int DEPTH   = 256;

  typedef struct {
    string       name;
    logic [15:0] len;
    bit          fixed;
    bit          bad_csum;
    bit          exp_err;
    bit          exp_run;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [15:0] words     [DEPTH];
  logic [15:0] model_mem [DEPTH];
  bit          known     [DEPTH];
  vec_t        vecs      [7];

  prog_mem_loader_if bus();

  prog_mem_loader #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH_W(8), .INIT_FILE(""),
    .AUTO_RUN(1'b1), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_word(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bus.uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      tick(CPB);
    end
    bus.uart_rx = stop;
    tick(CPB);
    bus.uart_rx = 1'b1;
    tick(3 * CPB);
  endtask

  // Reference: a legal LEN writes every data word at 0..LEN-1 (even when the
  // checksum later fails); the checksum is the byte sum of LEN and data.
  task automatic send_frame(input logic [15:0] len, input bit bad_csum, input int gap);
    logic [7:0] cs;
    int n;
    send_byte(8'hA5, 1'b1);
    check_bit("loading_after_sync", bus.loading, 1'b1);
    check_bit("cpu_held_after_sync", bus.cpu_reset, 1'b0);
    check_bit("err_cleared_after_sync", bus.load_err, 1'b0);
    send_byte(len[15:8], 1'b1);
    send_byte(len[7:0], 1'b1);
    cs = len[15:8] + len[7:0];
    n = (len == 16'd0 || int'(len) > DEPTH) ? 0 : int'(len);
    for (int i = 0; i < n; i++) begin
      send_byte(words[i][15:8], 1'b1);
      send_byte(words[i][7:0], 1'b1);
      cs = cs + words[i][15:8] + words[i][7:0];
      tick(gap);
    end
    if (n > 0) send_byte(cs + 8'(bad_csum), 1'b1);
    for (int i = 0; i < n; i++) begin
      model_mem[i] = words[i];
      known[i] = 1'b1;
    end
    tick(2);
  endtask

  task automatic verify_mem(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      if (known[a]) begin
        bus.adr = 11'(a);
        #1;
        check_word($sformatf("%s_mem%0d", tag, a), bus.dout, model_mem[a]);
      end
    end
    bus.adr = '0;
  endtask

  task automatic check_flags(input string tag, input logic ld, input logic err, input logic run);
    check_bit({tag, "_loading"}, bus.loading, ld);
    check_bit({tag, "_load_err"}, bus.load_err, err);
    check_bit({tag, "_cpu_reset"}, bus.cpu_reset, run);
  endtask

  initial begin
    vecs[0] = '{"good_2w",     16'h0002, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"rand_3w",     16'h0003, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"bad_csum",    16'h0002, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{"resend_good", 16'h0002, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"len_max",     16'h0100, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{"len_zero",    16'h0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{"len_0x101",   16'h0101, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

    bus.uart_rx = 1'b1;
    bus.adr = '0;
    reset = 1'b0;
    tick(5);
    check_flags("in_reset", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick(1);
    check_flags("after_reset", 1'b0, 1'b0, 1'b1);

    foreach (vecs[v]) begin
      for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
      if (vecs[v].fixed) begin
        words[0] = 16'h1234;
        words[1] = 16'h5678;
      end
      send_frame(vecs[v].len, vecs[v].bad_csum, 0);
      $display("frame %s len=%0h load_err=%0b cpu_reset=%0b", vecs[v].name, vecs[v].len,
               bus.load_err, bus.cpu_reset);
      check_flags(vecs[v].name, 1'b0, vecs[v].exp_err, vecs[v].exp_run);
      verify_mem(vecs[v].name);
    end
    bus.adr = 11'h1FF;
    #1;
    check_word("wrap_1ff", bus.dout, model_mem[255]);

    for (int f = 0; f < 3; f++) begin
      logic [15:0] len;
      len = 16'($urandom_range(1, 12));
      for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
      if (f == 0) words[0] = 16'hA5A5;
      send_frame(len, 1'b0, int'($urandom_range(0, 8)));
      $display("frame random%0d len=%0d load_err=%0b cpu_reset=%0b", f, len,
               bus.load_err, bus.cpu_reset);
      check_flags($sformatf("random%0d", f), 1'b0, 1'b0, 1'b1);
      verify_mem($sformatf("random%0d", f));
    end

    send_byte(8'h3C, 1'b0);
    $display("frame idle_ferr load_err=%0b cpu_reset=%0b", bus.load_err, bus.cpu_reset);
    check_flags("idle_ferr", 1'b0, 1'b0, 1'b1);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    tick(TIMEOUT - 80);
    check_bit("before_timeout_loading", bus.loading, 1'b1);
    tick(120);
    $display("frame timeout load_err=%0b cpu_reset=%0b", bus.load_err, bus.cpu_reset);
    check_flags("timeout", 1'b0, 1'b1, 1'b0);
    verify_mem("timeout");

    send_byte(8'hA5, 1'b1);
    check_bit("ferr_seq_err_cleared", bus.load_err, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b0);
    tick(2);
    $display("frame mid_ferr load_err=%0b cpu_reset=%0b", bus.load_err, bus.cpu_reset);
    check_flags("mid_ferr", 1'b0, 1'b1, 1'b0);

    send_byte(8'hA5, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h02, 1'b1);
    send_byte(8'h12, 1'b1);
    reset = 1'b0;
    tick(2);
    check_flags("mid_reset", 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    tick(2);
    for (int i = 0; i < DEPTH; i++) words[i] = 16'($urandom);
    send_frame(16'd6, 1'b0, 2);
    $display("frame after_reset len=6 load_err=%0b cpu_reset=%0b", bus.load_err, bus.cpu_reset);
    check_flags("post_reset_frame", 1'b0, 1'b0, 1'b1);
    bus.adr = 11'h105;
    #1;
    check_word("adr_0x105", bus.dout, words[5]);
    verify_mem("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
